// File: rtl/fcart_reg_pkg.sv
// Shared register-bridge definitions: register addresses, command layout
// and the SPI bridge state encoding.
package fcart_reg_pkg;

    localparam logic [3:0] REG_MAPPER   = 4'd0;
    localparam logic [3:0] REG_LAUNCHER = 4'd1;
    localparam int         CMD_READ_BIT = 7;
    localparam int         CNT_W        = 6;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WDATA,
        RDATA,
        DONE
    } bridge_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for one asynchronous SPI pin, with
// rise/fall detection on the synchronized value.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign q_o    = sync_q[STAGES-1];
    assign rise_o = !prev_q && q_o;
    assign fall_o = prev_q && !q_o;

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave that turns MCU write frames into a toggle-change
// register interface and answers read frames with a status snapshot.
module spi_reg_bridge
    import fcart_reg_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int WR_BITS     = 13,
    parameter int ADDR_BITS   = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 spi_sck,
    input  logic                 spi_cs_n,
    input  logic                 spi_mosi,
    output logic                 spi_miso,
    output logic                 spi_miso_oe,
    output logic [WR_BITS-1:0]   wr_reg,
    output logic [ADDR_BITS-1:0] wr_reg_addr,
    output logic                 wr_reg_changed,
    input  logic [31:0]          status_reg,
    output logic                 frame_err
);

    logic sck_rise, sck_fall, sck_s;
    logic cs_s, cs_rise, cs_fall;
    logic mosi_s;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
        .clk(clk), .reset_n(reset_n), .d_i(spi_sck),
        .q_o(sck_s), .rise_o(sck_rise), .fall_o(sck_fall)
    );

    // Chain resets low so a cs_n held low through reset is never seen as a fresh fall.
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_cs (
        .clk(clk), .reset_n(reset_n), .d_i(spi_cs_n),
        .q_o(cs_s), .rise_o(cs_rise), .fall_o(cs_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
        .clk(clk), .reset_n(reset_n), .d_i(spi_mosi),
        .q_o(mosi_s), .rise_o(), .fall_o()
    );

    bridge_state_t        state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [6:0]           cmd_q, cmd_d;
    logic [7:0]           cmd_nx;
    logic [WR_BITS-1:0]   data_q, data_d;
    logic [31:0]          shift_q, shift_d;
    logic                 miso_q, miso_d;
    logic                 pend_q, pend_d;
    logic                 rd_q, rd_d;
    logic [WR_BITS-1:0]   wr_q, wr_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic                 chg_q, chg_d;
    logic                 err_q, err_d;
    logic                 sck_up, sck_dn;

    assign sck_up = sck_rise && !cs_s && sck_s;
    assign sck_dn = sck_fall && !cs_s;
    assign cmd_nx = {cmd_q, mosi_s};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cmd_q   <= '0;
            data_q  <= '0;
            shift_q <= '0;
            miso_q  <= 1'b0;
            pend_q  <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= '0;
            addr_q  <= '0;
            chg_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            data_q  <= data_d;
            shift_q <= shift_d;
            miso_q  <= miso_d;
            pend_q  <= pend_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            chg_q   <= chg_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        data_d  = data_q;
        shift_d = shift_q;
        miso_d  = miso_q;
        pend_d  = 1'b0;
        rd_d    = rd_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        chg_d   = chg_q;
        err_d   = 1'b0;

        // A completed data word commits even if cs_n rises right after it.
        if (pend_q) begin
            wr_d   = data_q;
            addr_d = cmd_q[ADDR_BITS-1:0];
            chg_d  = ~chg_q;
        end

        if (cs_rise) begin
            state_d = IDLE;
            miso_d  = 1'b0;
            err_d   = (cnt_q != '0) &&
                      ((state_q == CMD) || (state_q == WDATA && !pend_q));
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_d = CMD;
                        cnt_d   = '0;
                        rd_d    = 1'b0;
                        miso_d  = 1'b0;
                    end
                end
                CMD: begin
                    if (sck_up) begin
                        cmd_d = cmd_nx[6:0];
                        cnt_d = sat_inc(cnt_q);
                        if (cnt_q == 6'd7) begin
                            cnt_d = '0;
                            if (cmd_nx[CMD_READ_BIT]) begin
                                state_d = RDATA;
                                shift_d = status_reg;
                                rd_d    = 1'b1;
                            end else begin
                                state_d = WDATA;
                            end
                        end
                    end
                end
                WDATA: begin
                    if (pend_q) begin
                        state_d = DONE;
                    end else if (sck_up) begin
                        data_d = {data_q[WR_BITS-2:0], mosi_s};
                        cnt_d  = sat_inc(cnt_q);
                        pend_d = (cnt_q == 6'd15);
                    end
                end
                RDATA: begin
                    if (sck_dn) begin
                        miso_d  = shift_q[31];
                        shift_d = {shift_q[30:0], 1'b0};
                        cnt_d   = sat_inc(cnt_q);
                        if (cnt_q == 6'd32) state_d = DONE;
                    end
                end
                DONE: begin
                end
            endcase
        end
    end

    assign spi_miso       = miso_q;
    assign spi_miso_oe    = !cs_s &&
                            ((state_q == RDATA) || (state_q == DONE && rd_q));
    assign wr_reg         = wr_q;
    assign wr_reg_addr    = addr_q;
    assign wr_reg_changed = chg_q;
    assign frame_err      = err_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench for spi_reg_bridge: frame vectors from a table plus
// hand-written abort, reset and collision sequences.
module tb_spi_reg_bridge;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        spi_sck = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_mosi = 1'b0;
    logic [31:0] status_reg = '0;
    logic        spi_miso, spi_miso_oe, wr_reg_changed, frame_err;
    logic [12:0] wr_reg;
    logic [3:0]  wr_reg_addr;

    spi_reg_bridge #(.SYNC_STAGES(2), .WR_BITS(13), .ADDR_BITS(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .wr_reg(wr_reg), .wr_reg_addr(wr_reg_addr),
        .wr_reg_changed(wr_reg_changed),
        .status_reg(status_reg), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int err_pulses = 0;

    always @(negedge clk) if (frame_err) err_pulses++;

    typedef struct {
        bit          rst;
        int          nb;
        logic [63:0] tx;
        logic [31:0] st;
        bit          rd;
        logic [12:0] ewr;
        logic [3:0]  ead;
        logic        ech;
        logic [39:0] erx;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_xfer(input logic b, output logic r);
        spi_mosi = b;
        wait_clk(8);
        spi_sck = 1'b1;
        r = spi_miso;
        wait_clk(8);
        spi_sck = 1'b0;
    endtask

    task automatic xfer(input logic [7:0] tx, input int n, output logic [7:0] rx);
        logic b;
        rx = '0;
        for (int i = 7; i > 7 - n; i--) begin
            bit_xfer(tx[i], b);
            rx[i] = b;
        end
    endtask

    task automatic cs_begin();
        spi_cs_n = 1'b0;
        wait_clk(8);
    endtask

    task automatic cs_end();
        wait_clk(8);
        spi_cs_n = 1'b1;
        wait_clk(10);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        wait_clk(1);
        reset_n = 1'b1;
        wait_clk(2);
    endtask

    initial begin
        logic [7:0]  rb;
        logic [39:0] rx_acc;
        int          e0;

        vecs[0] = '{1, 3, 64'h001A43_0000000000, 32'h0, 0,
                    13'h1A43, 4'd0, 1'b1, 40'h0};
        vecs[1] = '{1, 3, 64'h01FF0B_0000000000, 32'h0, 0,
                    13'h1F0B, 4'd1, 1'b1, 40'h0};
        vecs[2] = '{0, 3, 64'h01FF0B_0000000000, 32'h0, 0,
                    13'h1F0B, 4'd1, 1'b0, 40'h0};
        vecs[3] = '{0, 6, 64'h80FFFFFFFFFF_0000, 32'h0000_0355, 1,
                    13'h1F0B, 4'd1, 1'b0, 40'h00_0000_0355_00 >> 0};
        vecs[4] = '{0, 7, 64'h000007AABBCCDD_00, 32'h0, 0,
                    13'h0007, 4'd0, 1'b1, 40'h0};

        wait_clk(3);
        reset_n = 1'b1;
        wait_clk(3);
        chk("rst_wr_reg", wr_reg, 0);
        chk("rst_addr", wr_reg_addr, 0);
        chk("rst_changed", wr_reg_changed, 0);
        chk("rst_miso", spi_miso, 0);
        chk("rst_oe", spi_miso_oe, 0);
        chk("rst_err", frame_err, 0);

        for (int v = 0; v < 5; v++) begin
            if (vecs[v].rst) do_reset();
            e0 = err_pulses;
            status_reg = vecs[v].st;
            rx_acc = '0;
            cs_begin();
            for (int k = 0; k < vecs[v].nb; k++) begin
                if (k == 1 && vecs[v].rd) begin
                    chk($sformatf("v%0d_oe_in_frame", v), spi_miso_oe, 1);
                    status_reg = '0;
                end
                xfer(vecs[v].tx[63-8*k -: 8], 8, rb);
                if (k >= 1 && k <= 5) rx_acc = {rx_acc[31:0], rb};
            end
            cs_end();
            chk($sformatf("v%0d_wr_reg", v), wr_reg, vecs[v].ewr);
            chk($sformatf("v%0d_addr", v), wr_reg_addr, vecs[v].ead);
            chk($sformatf("v%0d_changed", v), wr_reg_changed, vecs[v].ech);
            chk($sformatf("v%0d_oe_after", v), spi_miso_oe, 0);
            chk($sformatf("v%0d_no_err", v), err_pulses, e0);
            if (vecs[v].rd) chk($sformatf("v%0d_rx", v), rx_acc, vecs[v].erx);
        end

        // abort after 12 data bits: error pulse, outputs untouched
        e0 = err_pulses;
        cs_begin();
        xfer(8'h00, 8, rb);
        xfer(8'hFF, 8, rb);
        xfer(8'hF0, 4, rb);
        cs_end();
        chk("abort_err", err_pulses, e0 + 1);
        chk("abort_wr_reg", wr_reg, 13'h0007);
        chk("abort_changed", wr_reg_changed, 1);

        // cs_n rise coincident with the final data sck rise
        e0 = err_pulses;
        cs_begin();
        xfer(8'h01, 8, rb);
        xfer(8'h12, 8, rb);
        xfer(8'h34, 7, rb);
        spi_mosi = 1'b1;
        wait_clk(8);
        spi_sck = 1'b1;
        spi_cs_n = 1'b1;
        wait_clk(8);
        spi_sck = 1'b0;
        wait_clk(10);
        chk("collide_err", err_pulses, e0 + 1);
        chk("collide_wr_reg", wr_reg, 13'h0007);
        chk("collide_addr", wr_reg_addr, 0);
        chk("collide_changed", wr_reg_changed, 1);

        // reset after 5 data bits discards the frame
        cs_begin();
        xfer(8'h01, 8, rb);
        xfer(8'hA8, 5, rb);
        do_reset();
        chk("midrst_wr_reg", wr_reg, 0);
        chk("midrst_changed", wr_reg_changed, 0);
        xfer(8'hFF, 3, rb);
        xfer(8'hFF, 8, rb);
        e0 = err_pulses;
        cs_end();
        chk("midrst_ignored", wr_reg_changed, 0);
        chk("midrst_no_err", err_pulses, e0);
        cs_begin();
        xfer(8'h00, 8, rb);
        xfer(8'h00, 8, rb);
        xfer(8'h07, 8, rb);
        cs_end();
        chk("post_rst_wr_reg", wr_reg, 13'h0007);
        chk("post_rst_addr", wr_reg_addr, 0);
        chk("post_rst_changed", wr_reg_changed, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
